uart_rx_deserializer: RTL

//  Serial UART receiver (8N1, LSB first) feeding the 32-bit word assembler.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_deserializer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Even parity holds when the XOR over data and parity bit is zero.
    function automatic logic even_parity_ok(input logic [UART_DATA_W-1:0] d, input logic p);
        return ~(^{d, p});
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RXD line; resets to the idle level (1).
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver (8N1, LSB first, oversampled by CLK_PER_BIT) producing one byte per valid strobe.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   RXD,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    output logic                   ferr,
    output logic                   busy,
    output rx_state_t              state_o
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);

    logic rxs;

    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    uart_rx_sync u_sync (
        .clk_i  (CLK),
        .rst_ni (RSTN),
        .d_i    (RXD),
        .q_o    (rxs)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                // Mid-start-bit re-check rejects short glitches on the idle line.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxs;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    parity_d = rxs;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (even_parity_ok(shreg_q, parity_q)) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
`else
                        data_d  = shreg_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before a new start edge is accepted.
                cnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign ferr    = ferr_q;
    assign busy    = (state_q != IDLE);
    assign state_o = state_q;

endmodule
